// File: rtl/tt_dfd_onehot_mon_pkg.sv
// Shared types and helpers for the DFD one-hot monitor.
// Latency: n/a (package only).
// Backpressure: n/a.
package tt_dfd_onehot_mon_pkg;

  typedef enum logic {
    ONEHOT_STRICT     = 1'b0,
    ONEHOT_ALLOW_ZERO = 1'b1
  } onehot_mode_e;

  // Index width that never collapses to zero bits for a single lane.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tt_dfd_onehot_lane_chk.sv
// Per-lane one-hot checker: stage-1 sample regs plus combinational ok/bad.
// Latency: bad asserts one cycle after the sample is presented.
// Backpressure: none, accepts one sample per cycle.
module tt_dfd_onehot_lane_chk
  import tt_dfd_onehot_mon_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mon_en,
  input  logic             valid,
  input  logic [WIDTH-1:0] vec,
  input  onehot_mode_e     mode,
  output logic             bad,
  output logic [WIDTH-1:0] cap_vec
);

  logic             v_q;
  logic [WIDTH-1:0] vec_q;
  onehot_mode_e     mode_q;
  logic [WIDTH-1:0] vec_m1;
  logic             ok;

  // Stage-1 capture; vector and mode hold their last valid sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q    <= 1'b0;
      vec_q  <= '0;
      mode_q <= ONEHOT_STRICT;
    end else begin
      v_q <= mon_en & valid;
      if (valid) begin
        vec_q  <= vec;
        mode_q <= mode;
      end
    end
  end

  // Power-of-two test on the held vector, with optional zero allowance.
  always_comb begin
    vec_m1 = vec_q - WIDTH'(1);
    ok     = ((vec_q != '0) && ((vec_q & vec_m1) == '0)) ||
             ((mode_q == ONEHOT_ALLOW_ZERO) && (vec_q == '0));
    bad    = v_q & ~ok;
  end

  assign cap_vec = vec_q;

endmodule

// File: rtl/tt_dfd_onehot_monitor.sv
// Multi-lane one-hot monitor with sticky status, saturating count and first-error capture.
// Latency: a sample presented at cycle t is reflected on all outputs at t+2.
// Backpressure: none, throughput one sample per lane per cycle.
module tt_dfd_onehot_monitor
  import tt_dfd_onehot_mon_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int NUM_CH   = 4,
  parameter  int CNT_W    = 16,
  localparam int CH_IDX_W = clog2_min1(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mon_en,
  input  logic [NUM_CH-1:0]       ch_valid,
  input  logic [NUM_CH*WIDTH-1:0] ch_vec,
  input  logic [NUM_CH-1:0]       ch_mode,
  input  logic                    clr,
  output logic [NUM_CH-1:0]       viol_pulse,
  output logic [NUM_CH-1:0]       viol_sticky,
  output logic [CNT_W-1:0]        viol_cnt,
  output logic                    first_vld,
  output logic [CH_IDX_W-1:0]     first_ch,
  output logic [WIDTH-1:0]        first_vec,
  output logic                    irq
);

  logic [NUM_CH-1:0] bad;
  logic [WIDTH-1:0]  lane_vec [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    tt_dfd_onehot_lane_chk #(.WIDTH(WIDTH)) u_chk (
      .clk     (clk),
      .reset   (reset),
      .mon_en  (mon_en),
      .valid   (ch_valid[i]),
      .vec     (ch_vec[i*WIDTH +: WIDTH]),
      .mode    (onehot_mode_e'(ch_mode[i])),
      .bad     (bad[i]),
      .cap_vec (lane_vec[i])
    );
  end

  logic [CNT_W:0]        pop;
  logic [CNT_W:0]        sum;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [NUM_CH-1:0]     sticky_nxt;
  logic [CH_IDX_W-1:0]   idx;
  logic                  any_bad;
  logic                  cap_load;

  // Popcount, saturating add, lowest-index priority pick; clr wipes the base first.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop = pop + (CNT_W+1)'(bad[i]);
    end
    sum     = {1'b0, (clr ? {CNT_W{1'b0}} : viol_cnt)} + pop;
    cnt_nxt = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bad[i]) idx = CH_IDX_W'(i);
    end

    any_bad    = |bad;
    sticky_nxt = (clr ? {NUM_CH{1'b0}} : viol_sticky) | bad;
    cap_load   = any_bad & (~first_vld | clr);
  end

  // Status registers: pulse, sticky, count, irq and first-error capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      viol_pulse  <= '0;
      viol_sticky <= '0;
      viol_cnt    <= '0;
      irq         <= 1'b0;
      first_vld   <= 1'b0;
      first_ch    <= '0;
      first_vec   <= '0;
    end else begin
      viol_pulse  <= bad;
      viol_sticky <= sticky_nxt;
      viol_cnt    <= cnt_nxt;
      irq         <= |sticky_nxt;
      if (cap_load) begin
        first_vld <= 1'b1;
        first_ch  <= idx;
        first_vec <= lane_vec[idx];
      end else if (clr) begin
        first_vld <= 1'b0;
        first_ch  <= '0;
        first_vec <= '0;
      end
    end
  end

endmodule
